// File: rtl/keypad_scanner_if.sv
// Pin-side bundle of the keypad scanner: column drive, row returns and the
// key-event outputs consumed by the control logic.
interface keypad_scanner_if;
    logic [3:0] o_select;
    logic [3:0] i_row;
    logic [3:0] o_key;
    logic       o_valid;
    logic       o_pressed;
    logic       o_error;

    modport master (
        output o_select,
        output o_key,
        output o_valid,
        output o_pressed,
        output o_error,
        input  i_row
    );

    modport slave (
        input  o_select,
        input  o_key,
        input  o_valid,
        input  o_pressed,
        input  o_error,
        output i_row
    );
endinterface

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low key matrix column by column, debounces complete
// 16-key frames and reports each new single-key press as a row*4+col code.
module keypad_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst_x,
    keypad_scanner_if.master kp
);
    localparam int               DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       STABLE_MAX = 4'(DEBOUNCE);

    typedef enum logic {IDLE, HELD} state_t;
    typedef enum logic [1:0] {CNT_ZERO, CNT_ONE, CNT_MANY} cnt_t;

    function automatic cnt_t count_class(input logic [15:0] f);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n = n + 5'(f[i]);
        if (n == 5'd0) return CNT_ZERO;
        if (n == 5'd1) return CNT_ONE;
        return CNT_MANY;
    endfunction

    // Frame bits are stored column-major (col*4+row); the reported code is row*4+col.
    function automatic logic [3:0] key_code(input logic [15:0] f);
        logic [3:0] code;
        code = '0;
        for (int i = 15; i >= 0; i--)
            if (f[i]) code = {2'(i % 4), 2'(i / 4)};
        return code;
    endfunction

    function automatic logic [1:0] col_index(input logic [3:0] sel);
        case (sel)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    logic [3:0]       row_p0, row_p1;
    logic [DIV_W-1:0] div;
    logic [15:0]      frame, prev_frame, frame_new;
    logic [3:0]       stable, stable_next;
    logic [1:0]       col;
    logic             tc, frame_end, same, accept;
    cnt_t             cnt;
    state_t           state;

    // Stage p0/p1: two-flop synchronizer for the asynchronous row returns
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            row_p0 <= 4'hF;
            row_p1 <= 4'hF;
        end else begin
            row_p0 <= kp.i_row;
            row_p1 <= row_p0;
        end
    end

    assign tc        = (div == DIV_LAST);
    assign col       = col_index(kp.o_select);
    assign frame_end = tc && (col == 2'd3);

    always_comb begin
        frame_new = frame;
        frame_new[{col, 2'b00} +: 4] = ~row_p1;
    end

    assign same        = (frame_new == prev_frame);
    assign stable_next = !same ? 4'd0 :
                         (stable == STABLE_MAX) ? stable : stable + 4'd1;
    assign accept      = frame_end && same && (stable_next == STABLE_MAX);
    assign cnt         = count_class(frame_new);

    // Column scan, frame assembly and debounce counting
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            div         <= '0;
            kp.o_select <= 4'b1110;
            frame       <= '0;
            prev_frame  <= '0;
            stable      <= '0;
        end else begin
            div <= tc ? '0 : div + 1'b1;
            if (tc) begin
                frame       <= frame_new;
                kp.o_select <= {kp.o_select[2:0], kp.o_select[3]};
            end
            if (frame_end) begin
                prev_frame <= frame_new;
                stable     <= stable_next;
            end
        end
    end

    // Key-event state machine, fed by accepted frames only
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state        <= IDLE;
            kp.o_key     <= '0;
            kp.o_valid   <= 1'b0;
            kp.o_pressed <= 1'b0;
            kp.o_error   <= 1'b0;
        end else begin
            kp.o_valid <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (cnt == CNT_ONE) begin
                            kp.o_key     <= key_code(frame_new);
                            kp.o_valid   <= 1'b1;
                            kp.o_pressed <= 1'b1;
                            kp.o_error   <= 1'b0;
                            state        <= HELD;
                        end else if (cnt == CNT_MANY) begin
                            kp.o_pressed <= 1'b1;
                            kp.o_error   <= 1'b1;
                            state        <= HELD;
                        end else begin
                            kp.o_pressed <= 1'b0;
                            kp.o_error   <= 1'b0;
                        end
                    end
                    HELD: begin
                        // A key change without full release never reports.
                        if (cnt == CNT_ZERO) begin
                            kp.o_pressed <= 1'b0;
                            kp.o_error   <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            kp.o_pressed <= 1'b1;
                            kp.o_error   <= (cnt == CNT_MANY);
                        end
                    end
                endcase
            end
        end
    end
endmodule
